// File: rtl/vga_pattern_sequencer_if.sv
// Control/status bundle between the pattern sequencer and its neighbours.
//   master : drives vsync, auto_en, next_req, prev_req; observes outputs
//   slave  : the sequencer itself
//   vsync           - high during active rows, low during vertical blanking
//   auto_en         - enable automatic pattern advance
//   next_req        - one-cycle pulse: step to next pattern
//   prev_req        - one-cycle pulse: step to previous pattern
//   pattern_sel     - current pattern index
//   pattern_changed - one-cycle pulse when pattern_sel updates
//   blank           - force downstream RGB to 0
//   frame_tick      - one-cycle pulse per vsync falling edge
interface vga_pattern_sequencer_if #(
  parameter int PATTERN_BITS = 3
);
  logic                    vsync;
  logic                    auto_en;
  logic                    next_req;
  logic                    prev_req;
  logic [PATTERN_BITS-1:0] pattern_sel;
  logic                    pattern_changed;
  logic                    blank;
  logic                    frame_tick;

  modport master (
    output vsync, auto_en, next_req, prev_req,
    input  pattern_sel, pattern_changed, blank, frame_tick
  );

  modport slave (
    input  vsync, auto_en, next_req, prev_req,
    output pattern_sel, pattern_changed, blank, frame_tick
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern selector for the VGA pattern generator.
// Pattern changes (auto every FRAMES_PER_PATTERN frames, or manual next/prev
// requests) take effect only at the vsync falling edge, and may be followed by
// BLANK_FRAMES frames of forced black output.
// Ports:
//   clock   - pixel clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of vga_pattern_sequencer_if (see interface header)
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS       = 8,
  parameter int PATTERN_BITS       = 3,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int FRAME_CNT_WIDTH    = 8,
  parameter int BLANK_FRAMES       = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  vga_pattern_sequencer_if.slave bus
);

  // blank_cnt only needs to hold BLANK_FRAMES-1
  localparam int BLANK_W = (BLANK_FRAMES > 2) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [PATTERN_BITS-1:0]    SEL_MAX    = PATTERN_BITS'(NUM_PATTERNS - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_MAX    = FRAME_CNT_WIDTH'(FRAMES_PER_PATTERN - 1);
  localparam logic [BLANK_W-1:0]         BLANK_LOAD = (BLANK_FRAMES > 0) ?
                                                      BLANK_W'(BLANK_FRAMES - 1) : '0;

  typedef enum logic [1:0] {P_NONE, P_NEXT, P_PREV} pend_t;
  typedef enum logic       {S_SHOW, S_BLANK}        state_t;

  logic                       vsync_q;
  pend_t                      pending;
  state_t                     state;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic [BLANK_W-1:0]         blank_cnt;
  logic [PATTERN_BITS-1:0]    sel_q;
  logic                       changed_q;
  logic                       blank_q;
  logic                       tick_q;

  logic                    fall;
  logic                    manual;
  logic                    auto_hit;
  logic                    do_change;
  logic [PATTERN_BITS-1:0] sel_inc;
  logic [PATTERN_BITS-1:0] sel_dec;
  logic [PATTERN_BITS-1:0] sel_nxt;

  always_comb begin
    fall      = vsync_q & ~bus.vsync;
    sel_inc   = (sel_q == SEL_MAX) ? '0 : sel_q + PATTERN_BITS'(1);
    sel_dec   = (sel_q == '0) ? SEL_MAX : sel_q - PATTERN_BITS'(1);
    // a pending manual request wins over the auto counter on the same edge
    manual    = fall && (pending != P_NONE);
    auto_hit  = fall && (pending == P_NONE) && bus.auto_en && (frame_cnt == CNT_MAX);
    do_change = manual | auto_hit;
    sel_nxt   = (manual && pending == P_PREV) ? sel_dec : sel_inc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b0;
      pending   <= P_NONE;
      state     <= S_SHOW;
      frame_cnt <= '0;
      blank_cnt <= '0;
      sel_q     <= '0;
      changed_q <= 1'b0;
      blank_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      vsync_q   <= bus.vsync;
      tick_q    <= fall;
      changed_q <= do_change;
      if (do_change) sel_q <= sel_nxt;

      // A request seen on the edge cycle itself is kept for the following
      // edge; both requests at once are dropped.
      if (bus.next_req && !bus.prev_req)      pending <= P_NEXT;
      else if (bus.prev_req && !bus.next_req) pending <= P_PREV;
      else if (manual)                        pending <= P_NONE;

      if (fall) begin
        if (do_change)        frame_cnt <= '0;
        else if (bus.auto_en) frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
      end

      case (state)
        S_SHOW: begin
          if (do_change && BLANK_FRAMES > 0) begin
            state     <= S_BLANK;
            blank_q   <= 1'b1;
            blank_cnt <= BLANK_LOAD;
          end
        end
        S_BLANK: begin
          if (do_change) begin
            blank_cnt <= BLANK_LOAD;
          end else if (fall) begin
            if (blank_cnt == '0) begin
              state   <= S_SHOW;
              blank_q <= 1'b0;
            end else begin
              blank_cnt <= blank_cnt - BLANK_W'(1);
            end
          end
        end
        default: begin
          state   <= S_SHOW;
          blank_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern_sel     = sel_q;
  assign bus.pattern_changed = changed_q;
  assign bus.blank           = blank_q;
  assign bus.frame_tick      = tick_q;

endmodule
